param_window_seq_detector: RTL

//  Next-generation sliding-window serial sequence detector with a parametrised window and NPAT runtime-programmable masked patterns.
//  - Serial bits enter a W-bit window under in_valid; each cycle the window is compared against every pattern.
//  - Per-pattern one-cycle dec pulses and saturating match counters are produced.
//  - Overlapping or non-overlapping detection is selectable; sits between the serial front-end and the control/status logic.

---
 rtl/param_window_seq_detector_pkg.sv | 17 +
 rtl/param_window_seq_detector_if.sv | 34 +++
 rtl/param_window_seq_detector_match.sv | 20 ++
 rtl/param_window_seq_detector.sv | 97 +++++++++
 4 files changed

// File: rtl/param_window_seq_detector_pkg.sv
// Shared constants and configuration record for the sliding-window sequence detector.
// Slot configuration is stored at MAX_W width; the top zero-extends its W-bit inputs.
package seq_det_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_NPAT  = 2;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_W     = 64;

    localparam int CNT_SAT_DEF = (1 << DEF_CNT_W) - 1;

    typedef struct packed {
        logic [MAX_W-1:0] pattern;
        logic [MAX_W-1:0] mask;
    } match_cfg_t;

endpackage

// File: rtl/param_window_seq_detector_if.sv
// Serial input, configuration and status bundle of the sequence detector.
interface param_window_seq_detector_if #(
    parameter int W     = seq_det_pkg::DEF_W,
    parameter int NPAT  = seq_det_pkg::DEF_NPAT,
    parameter int CNT_W = seq_det_pkg::DEF_CNT_W
);
    import seq_det_pkg::*;

    localparam int IDX_W = (NPAT > 1) ? $clog2(NPAT) : 1;

    logic                  in_valid;
    logic                  in;
    logic                  ovl;
    logic                  flush;
    logic                  cfg_we;
    logic [IDX_W-1:0]      cfg_idx;
    logic [W-1:0]          cfg_pattern;
    logic [W-1:0]          cfg_mask;
    logic                  cnt_clr;
    logic [NPAT-1:0]       dec;
    logic                  hit_any;
    logic [NPAT*CNT_W-1:0] match_cnt;

    modport master (
        output in_valid, in, ovl, flush, cfg_we, cfg_idx, cfg_pattern, cfg_mask, cnt_clr,
        input  dec, hit_any, match_cnt
    );

    modport slave (
        input  in_valid, in, ovl, flush, cfg_we, cfg_idx, cfg_pattern, cfg_mask, cnt_clr,
        output dec, hit_any, match_cnt
    );

endinterface

// File: rtl/param_window_seq_detector_match.sv
// Masked compare of the next window against one slot; only qualifies once W bits are in.
module seq_window_match
    import seq_det_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] win_next_i,
    input  logic         fill_full_i,
    input  match_cfg_t   cfg_i,
    output logic         match_o
);

    logic [MAX_W-1:0] win_ext;

    assign win_ext = MAX_W'(win_next_i);
    // An all-zero mask marks the slot as disabled rather than "always match".
    assign match_o = fill_full_i && (cfg_i.mask != '0)
                     && (((win_ext ^ cfg_i.pattern) & cfg_i.mask) == '0);

endmodule

// File: rtl/param_window_seq_detector.sv
// Sliding-window serial detector: W-bit window, NPAT programmable masked slots,
// registered per-slot pulses and saturating match counters.
module param_window_seq_detector
    import seq_det_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int NPAT  = DEF_NPAT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    param_window_seq_detector_if.slave   bus
);

    localparam int FILL_W = $clog2(W + 1);

    logic [W-1:0]      win_q, win_d, win_next;
    logic [FILL_W-1:0] fill_q, fill_d, fill_next;
    logic              fill_full;
    logic              shift_en;
    logic [NPAT-1:0]   match;
    logic [NPAT-1:0]   dec_q, dec_d;
    logic              hit_q, hit_d;
    match_cfg_t        cfg_q [NPAT];
    match_cfg_t        cfg_d [NPAT];
    logic [CNT_W-1:0]  cnt_q [NPAT];
    logic [CNT_W-1:0]  cnt_d [NPAT];

    assign shift_en  = bus.in_valid && !bus.flush;
    assign win_next  = bus.in_valid ? {win_q[W-2:0], bus.in} : win_q;
    assign fill_next = (bus.in_valid && (fill_q != FILL_W'(W))) ? fill_q + 1'b1 : fill_q;
    assign fill_full = (fill_next == FILL_W'(W));

    for (genvar gi = 0; gi < NPAT; gi++) begin : g_slot
        seq_window_match #(.W(W)) u_match (
            .win_next_i  (win_next),
            .fill_full_i (fill_full),
            .cfg_i       (cfg_q[gi]),
            .match_o     (match[gi])
        );
        assign bus.match_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        dec_d  = shift_en ? match : '0;
        hit_d  = |dec_d;
        cfg_d  = cfg_q;
        cnt_d  = cnt_q;

        if (bus.flush) begin
            win_d  = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            win_d  = win_next;
            // Non-overlapping: bits stay in the window but must all be replaced before the next hit.
            fill_d = (!bus.ovl && (match != '0)) ? '0 : fill_next;
        end

        for (int p = 0; p < NPAT; p++) begin
            if (bus.cnt_clr) begin
                cnt_d[p] = CNT_W'(dec_d[p]);
            end else if (dec_d[p] && (cnt_q[p] != '1)) begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end
        end

        if (bus.cfg_we && (int'(bus.cfg_idx) < NPAT)) begin
            cfg_d[bus.cfg_idx] = '{pattern: MAX_W'(bus.cfg_pattern), mask: MAX_W'(bus.cfg_mask)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
            dec_q  <= '0;
            hit_q  <= 1'b0;
            for (int p = 0; p < NPAT; p++) begin
                cfg_q[p] <= '0;
                cnt_q[p] <= '0;
            end
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            dec_q  <= dec_d;
            hit_q  <= hit_d;
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.dec     = dec_q;
    assign bus.hit_any = hit_q;

endmodule
